plus_operator_adder: RTL and testbench

- 32-bit (parameterisable) two's-complement adder with carry-in: Sum = A + B + Cin.
- Combinational result path (zero latency) for datapath use, plus a registered copy of result and status flags for pipelined consumers.
- Sits in the arithmetic datapath as the reference "plus-operator" adder against which structural adders are compared.

---
 rtl/plus_operator_adder.sv | 108 ++++++++++
 tb/tb_plus_operator_adder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/plus_operator_adder.sv
`default_nettype none
// ============================================================================
// Module      : plus_operator_adder
// Description : Reference two's-complement adder built on the '+' operator.
//               Computes Sum = A + B + Cin combinationally (zero latency) and
//               keeps a registered copy of the result and status flags for
//               pipelined consumers.
// Ports       :
//   clk         - clock; registered outputs update on the rising edge
//   rst_n       - asynchronous active-low reset
//   A, B        - WIDTH-bit operands (unsigned or two's complement)
//   Cin         - carry-in added at bit 0
//   En          - load enable for the registered result/flags
//   Sum         - combinational low WIDTH bits of A+B+Cin
//   Cout        - combinational carry out of the MSB (unsigned overflow)
//   Overflow    - combinational signed overflow
//   SumReg      - registered Sum
//   CoutReg     - registered Cout
//   OverflowReg - registered Overflow
//   ZeroReg     - registered (Sum == 0); reads 1 while in reset
//   NegReg      - registered Sum[MSB]
//   ValidReg    - En delayed by one cycle (result-valid strobe)
// Revision    : 1.0 - initial release
// ============================================================================
module plus_operator_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             En,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic [WIDTH-1:0] SumReg,
  output logic             CoutReg,
  output logic             OverflowReg,
  output logic             ZeroReg,
  output logic             NegReg,
  output logic             ValidReg
);

  localparam int c_MSB = WIDTH - 1;

  // The sum is formed at WIDTH+1 bits so the carry out of the MSB is kept
  // rather than being lost to truncation.
  logic [WIDTH:0]   w_sum_ext;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_zero;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;
  logic             r_valid;

  assign w_sum_ext = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
  assign w_sum     = w_sum_ext[WIDTH-1:0];
  assign w_cout    = w_sum_ext[WIDTH];

  // Signed overflow: operands agree in sign but the result does not.
  // Cin enters through the sum, so no separate term is needed.
  assign w_ovf  = (A[c_MSB] == B[c_MSB]) && (w_sum[c_MSB] != A[c_MSB]);
  assign w_zero = (w_sum == '0);

  // Result/flag capture, gated by En.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;  // cleared result of zero reads as zero
      r_neg  <= 1'b0;
    end else if (En) begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
      r_neg  <= w_sum[c_MSB];
    end
  end

  // Valid strobe follows En every cycle, independent of the capture gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= En;
    end
  end

  assign Sum         = w_sum;
  assign Cout        = w_cout;
  assign Overflow    = w_ovf;
  assign SumReg      = r_sum;
  assign CoutReg     = r_cout;
  assign OverflowReg = r_ovf;
  assign ZeroReg     = r_zero;
  assign NegReg      = r_neg;
  assign ValidReg    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_plus_operator_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_plus_operator_adder
// Description : Directed self-checking bench for plus_operator_adder.
//               Inputs change on the falling edge; combinational outputs are
//               checked 1 time unit later, registered outputs 1 time unit
//               after the following rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plus_operator_adder;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             En;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;
  logic [WIDTH-1:0] SumReg;
  logic             CoutReg;
  logic             OverflowReg;
  logic             ZeroReg;
  logic             NegReg;
  logic             ValidReg;

  int n_checks;
  int n_fail;

  plus_operator_adder #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (A),
    .B          (B),
    .Cin        (Cin),
    .En         (En),
    .Sum        (Sum),
    .Cout       (Cout),
    .Overflow   (Overflow),
    .SumReg     (SumReg),
    .CoutReg    (CoutReg),
    .OverflowReg(OverflowReg),
    .ZeroReg    (ZeroReg),
    .NegReg     (NegReg),
    .ValidReg   (ValidReg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a vector on the falling edge and let it settle.
  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic en);
    @(negedge clk);
    A   = a;
    B   = b;
    Cin = cin;
    En  = en;
    #1;
  endtask

  task automatic check_comb(input string tag, input logic [WIDTH-1:0] s,
                            input logic c, input logic v);
    check({tag, ".Sum"}, Sum, s);
    check({tag, ".Cout"}, {31'd0, Cout}, {31'd0, c});
    check({tag, ".Overflow"}, {31'd0, Overflow}, {31'd0, v});
  endtask

  task automatic check_regs(input string tag, input logic [WIDTH-1:0] s,
                            input logic c, input logic v, input logic z,
                            input logic n, input logic vld);
    check({tag, ".SumReg"}, SumReg, s);
    check({tag, ".CoutReg"}, {31'd0, CoutReg}, {31'd0, c});
    check({tag, ".OverflowReg"}, {31'd0, OverflowReg}, {31'd0, v});
    check({tag, ".ZeroReg"}, {31'd0, ZeroReg}, {31'd0, z});
    check({tag, ".NegReg"}, {31'd0, NegReg}, {31'd0, n});
    check({tag, ".ValidReg"}, {31'd0, ValidReg}, {31'd0, vld});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    A        = '0;
    B        = '0;
    Cin      = 1'b0;
    En       = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;  // genuine falling edge on reset
    #2;
    check_regs("reset", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset must dominate a rising edge even with En high.
    En = 1'b1;
    A  = 32'h0000_0005;
    tick();
    check_regs("reset_edge", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // Positive signed overflow.
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    check_comb("pos_ovf", 32'h8000_0000, 1'b0, 1'b1);
    tick();
    check_regs("pos_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Negative signed overflow with unsigned carry.
    drive(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check_comb("neg_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);
    tick();
    check_regs("neg_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Mixed-sign operands.
    drive(32'd100, 32'hFFFF_FF38, 1'b0, 1'b1);  // 100 + -200
    check_comb("mix1", 32'hFFFF_FF9C, 1'b0, 1'b0);
    drive(32'd1234, 32'hFFFF_E9D2, 1'b1, 1'b1);  // 1234 + -5678 + 1
    check_comb("mix2", 32'hFFFF_EEA5, 1'b0, 1'b0);
    drive(32'hFFFF_D96C, 32'd5432, 1'b0, 1'b1);  // -9876 + 5432
    check_comb("mix3", 32'hFFFF_EEA4, 1'b0, 1'b0);
    tick();
    check_regs("mix3", 32'hFFFF_EEA4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Same sign, with and without carry-in.
    drive(32'd50, 32'd100, 1'b0, 1'b1);
    check_comb("same_pos", 32'd150, 1'b0, 1'b0);
    drive(32'hFFFF_FFCE, 32'hFFFF_FF9C, 1'b1, 1'b1);  // -50 + -100 + 1
    check_comb("same_neg", 32'hFFFF_FF6B, 1'b1, 1'b0);
    tick();
    check_regs("same_neg", 32'hFFFF_FF6B, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Zero result.
    drive(32'h0, 32'h0, 1'b0, 1'b1);
    check_comb("zero", 32'h0, 1'b0, 1'b0);
    tick();
    check_regs("zero", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Wrap-around through carry-in.
    drive(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    check_comb("wrap", 32'h0, 1'b1, 1'b0);
    tick();
    check_regs("wrap", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // Capture 150, then drop En: registers hold, ValidReg falls.
    drive(32'd50, 32'd100, 1'b0, 1'b1);
    tick();
    check_regs("cap150", 32'd150, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);
    check_comb("hold_in", 32'hFFFF_FFFF, 1'b0, 1'b1);
    tick();
    check_regs("hold1", 32'd150, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_regs("hold2", 32'd150, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Recapture a negative result, then reset between edges.
    drive(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    tick();
    check_regs("pre_rst", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    A     = 32'd3;
    B     = 32'd4;
    Cin   = 1'b0;
    rst_n = 1'b0;
    #1;
    check_regs("mid_rst", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_comb("mid_rst", 32'd7, 1'b0, 1'b0);
    tick();
    check_regs("rst_hold", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // First capture after release.
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'd3, 32'd4, 1'b1, 1'b1);
    check_comb("post_rst", 32'd8, 1'b0, 1'b0);
    tick();
    check_regs("post_rst", 32'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
